// File: rtl/alu_sequencer.sv
// Control sequencer for the simple CPU datapath: fetches a 9-bit instruction on run
// and steps T0..T3, decoding ALU, register-file and bus-source strobes from (step, IR).
module alu_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int IR_WIDTH   = 9
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  ain,
  output logic                  gin,
  output logic                  sub,
  output logic                  gout,
  output logic                  dinout,
  output logic [7:0]            rin,
  output logic [7:0]            rout,
  output logic                  done
);

  typedef enum logic [1:0] {T0, T1, T2, T3} step_e;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  step_e               step_q, step_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [2:0]          op, rx, ry;

  // Upper din bits only ever carry immediates for the datapath.
  logic unused_din;
  assign unused_din = ^din[DATA_WIDTH-1:IR_WIDTH];

  assign op = ir_q[IR_WIDTH-1 -: 3];
  assign rx = ir_q[IR_WIDTH-4 -: 3];
  assign ry = ir_q[IR_WIDTH-7 -: 3];

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'b1 << idx;
  endfunction

  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    ain    = 1'b0;
    gin    = 1'b0;
    sub    = 1'b0;
    gout   = 1'b0;
    dinout = 1'b0;
    rin    = '0;
    rout   = '0;
    done   = 1'b0;
    case (step_q)
      T0: begin
        if (run) begin
          ir_d   = din[IR_WIDTH-1:0];
          step_d = T1;
        end
      end
      T1: begin
        step_d = T0;
        case (op)
          OP_MV: begin
            rout = onehot(ry);
            rin  = onehot(rx);
            done = 1'b1;
          end
          OP_MVI: begin
            dinout = 1'b1;
            rin    = onehot(rx);
            done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout   = onehot(rx);
            ain    = 1'b1;
            step_d = T2;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        rout   = onehot(ry);
        gin    = 1'b1;
        sub    = (op == OP_SUB);
        step_d = T3;
      end
      T3: begin
        gout   = 1'b1;
        rin    = onehot(rx);
        done   = 1'b1;
        step_d = T0;
      end
      default: step_d = T0;
    endcase
    // Reset silences every strobe in the same cycle, including an aborted instruction.
    if (!resetn) begin
      ain    = 1'b0;
      gin    = 1'b0;
      sub    = 1'b0;
      gout   = 1'b0;
      dinout = 1'b0;
      rin    = '0;
      rout   = '0;
      done   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes expected strobe vectors with their
// due cycle; a monitor pops on every active cycle. A small register file/ALU closes the loop.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        resetn, run;
  logic [15:0] din;
  logic        ain, gin, sub, gout, dinout, done;
  logic [7:0]  rin, rout;

  alu_sequencer #(.DATA_WIDTH(16), .IR_WIDTH(9)) dut (
    .clock(clock), .resetn(resetn), .run(run), .din(din),
    .ain(ain), .gin(gin), .sub(sub), .gout(gout), .dinout(dinout),
    .rin(rin), .rout(rout), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath: register file, A, G and bus mux driven by the sequencer strobes.
  logic [15:0] R [8];
  logic [15:0] A, G, bus;
  always_comb begin
    bus = '0;
    if (dinout) bus = din;
    else if (gout) bus = G;
    else for (int i = 0; i < 8; i++) if (rout[i]) bus = R[i];
  end
  always @(posedge clock) begin
    if (ain) A <= bus;
    if (gin) G <= sub ? A - bus : A + bus;
    for (int i = 0; i < 8; i++) if (rin[i]) R[i] <= bus;
  end

  typedef struct packed {
    logic       ain, gin, sub, gout, dinout;
    logic [7:0] rin, rout;
    logic       done;
  } outs_t;
  typedef struct {
    outs_t o;
    int    c;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m [8];
  bit          stim_done = 1'b0;
  int          total = 0, bad = 0;

  function automatic logic [7:0] oh(input logic [2:0] i);
    logic [7:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    repeat (n) begin
      din = 16'($urandom);
      tick();
    end
  endtask

  // Issue one instruction starting in T0; records what every following cycle must show.
  task automatic issue(input logic [8:0] ir, input logic [15:0] imm, input bit abort);
    logic [2:0] op, rx, ry;
    outs_t e;
    int c0, len;
    op = ir[8:6]; rx = ir[5:3]; ry = ir[2:0];
    c0 = cyc;
    run = 1'b1;
    din = {7'b0, ir};
    len = 2;
    e = '0;
    case (op)
      3'd0: begin
        e.rout = oh(ry); e.rin = oh(rx); e.done = 1'b1;
        q.push_back('{o: e, c: c0 + 1});
        m[rx] = m[ry];
      end
      3'd1: begin
        e.dinout = 1'b1; e.rin = oh(rx); e.done = 1'b1;
        q.push_back('{o: e, c: c0 + 1});
        m[rx] = imm;
      end
      3'd2, 3'd3: begin
        len = 4;
        e.rout = oh(rx); e.ain = 1'b1;
        q.push_back('{o: e, c: c0 + 1});
        if (!abort) begin
          e = '0; e.rout = oh(ry); e.gin = 1'b1; e.sub = (op == 3'd3);
          q.push_back('{o: e, c: c0 + 2});
          e = '0; e.gout = 1'b1; e.rin = oh(rx); e.done = 1'b1;
          q.push_back('{o: e, c: c0 + 3});
          m[rx] = (op == 3'd3) ? m[rx] - m[ry] : m[rx] + m[ry];
        end
      end
      default: begin
        e.done = 1'b1;
        q.push_back('{o: e, c: c0 + 1});
      end
    endcase
    tick();
    din = imm;
    run = 1'($urandom);
    if (abort && len == 4) begin
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
    end else begin
      repeat (len - 1) begin
        tick();
        din = 16'($urandom);
        run = 1'($urandom);
      end
    end
    run = 1'b0;
  endtask

  // Stimulus
  initial begin
    logic [8:0] ir;
    resetn = 1'b0;
    run    = 1'b1;
    din    = 16'o012;
    tick();
    tick();
    resetn = 1'b1;
    issue(9'o012, 16'h1234, 1'b0);
    idle(1);
    for (int i = 0; i < 8; i++) issue({3'b001, 3'(i), 3'b000}, 16'($urandom), 1'b0);
    for (int k = 0; k < 60; k++) begin
      ir = 9'($urandom);
      issue(ir, 16'($urandom), (ir[8:6] == 3'd2) && ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    issue(9'b001_101_000, 16'h00AB, 1'b0);
    idle(1);
    issue(9'b110_000_000, 16'hFFFF, 1'b0);
    issue(9'b010_011_100, 16'h0000, 1'b1);
    idle(1);
    issue(9'b000_011_011, 16'h0000, 1'b0);
    issue(9'b001_000_000, 16'd5, 1'b0);
    issue(9'b001_001_000, 16'd9, 1'b0);
    issue(9'b010_000_001, 16'h0000, 1'b0);
    issue(9'b000_010_000, 16'h0000, 1'b0);
    issue(9'b001_001_000, 16'd7, 1'b0);
    issue(9'b001_110_000, 16'd3, 1'b0);
    issue(9'b011_001_110, 16'h0000, 1'b0);
    idle(3);
    stim_done = 1'b1;
  end

  // Monitor
  initial begin
    outs_t v;
    exp_t  e;
    forever begin
      @(negedge clock);
      v = {ain, gin, sub, gout, dinout, rin, rout, done};
      total++;
      if ($countones(rout) + int'(gout) + int'(dinout) > 1) begin
        bad++;
        $display("FAIL bus_excl cyc=%0d rout=%h gout=%b dinout=%b, required at most one", cyc, rout, gout, dinout);
      end
      if (!resetn) begin
        total++;
        if (v != '0) begin
          bad++;
          $display("FAIL reset_outs cyc=%0d got=%h required=0", cyc, v);
        end
      end else if (v != '0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected cyc=%0d got=%h required=idle", cyc, v);
        end else begin
          e = q.pop_front();
          if (e.o != v || e.c != cyc) begin
            bad++;
            $display("FAIL strobes cyc=%0d got=%h required=%h at cyc %0d", cyc, v, e.o, e.c);
          end
        end
      end
      if (stim_done || cyc > 5000) begin
        total++;
        if (!stim_done || q.size() != 0) begin
          bad++;
          $display("FAIL drain pending=%0d stim_done=%0b required pending=0", q.size(), stim_done);
        end
        for (int i = 0; i < 8; i++) begin
          total++;
          if (R[i] !== m[i]) begin
            bad++;
            $display("FAIL reg R%0d got=%h required=%h", i, R[i], m[i]);
          end
        end
        total++;
        if (R[0] !== 16'd14 || R[1] !== 16'd4 || R[2] !== 16'd14 || R[6] !== 16'd3) begin
          bad++;
          $display("FAIL directed_regs got R0=%0d R1=%0d R2=%0d R6=%0d required 14 4 14 3", R[0], R[1], R[2], R[6]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

endmodule
